// File: rtl/tx_pkg.sv
// rtl/tx_pkg.sv - shared state encoding and sizing helpers for the message transmitter
package tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_GAP   = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  // "HAPPY BIRTHDAY" is 14 bytes long
  localparam int DEF_MSG_LEN = 14;

  // Width that can hold the indices 0..n-1, never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width that can hold the values 0..n, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

  localparam int DEF_IDX_W = idx_width(DEF_MSG_LEN);

endpackage

// File: rtl/tx_seq_ctrl.sv
// rtl/tx_seq_ctrl.sv - walks message byte indices into the serializer with gaps and bounded repeat
module tx_seq_ctrl
  import tx_pkg::*;
#(
  parameter int MSG_LEN    = DEF_MSG_LEN,
  parameter int IDX_W      = idx_width(MSG_LEN),
  parameter int GAP_CYCLES = 8,
  parameter int CNT_W      = 8,
  parameter int REPEAT     = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_tx_en_n,
  input  logic             i_byte_rdy,
  input  logic             i_tx_idle,
  output logic             o_byte_vld,
  output logic [IDX_W-1:0] o_byte_idx,
  output logic             o_busy,
  output logic             o_seq_done,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_seq_count
);

  localparam int RUN_W = cnt_width(REPEAT);
  localparam int GAP_W = cnt_width(GAP_CYCLES);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(MSG_LEN - 1);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(REPEAT);
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_CYCLES);

  state_t           state;
  logic [RUN_W-1:0] run_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             stop_pend;

  logic [RUN_W-1:0] run_nxt;
  logic             run_limit_hit;
  logic             stop_now;

  // Messages in this enable run once the current one completes; a zero
  // REPEAT means the run never ends on its own.
  assign run_nxt       = run_cnt + RUN_W'(1);
  assign run_limit_hit = (REPEAT != 0) && (run_nxt == RUN_LIMIT);

  // A release seen anywhere in SEND/DRAIN is remembered so the message is
  // finished first and the controller then parks in IDLE.
  assign stop_now = stop_pend | i_tx_en_n;

  // Sequencer FSM; every output is a register updated alongside the state
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      run_cnt     <= '0;
      gap_cnt     <= '0;
      stop_pend   <= 1'b0;
      o_byte_vld  <= 1'b0;
      o_byte_idx  <= '0;
      o_busy      <= 1'b0;
      o_seq_done  <= 1'b0;
      o_halted    <= 1'b0;
      o_seq_count <= '0;
    end else begin
      o_seq_done <= 1'b0;

      case (state)
        ST_IDLE: begin
          run_cnt   <= '0;
          stop_pend <= 1'b0;
          if (!i_tx_en_n) begin
            state      <= ST_SEND;
            o_byte_vld <= 1'b1;
            o_byte_idx <= '0;
            o_busy     <= 1'b1;
          end
        end

        ST_SEND: begin
          if (i_tx_en_n) begin
            stop_pend <= 1'b1;
          end
          // vld is always high here, so rdy alone marks a handshake
          if (i_byte_rdy) begin
            if (o_byte_idx == LAST_IDX) begin
              o_byte_vld <= 1'b0;
              state      <= ST_DRAIN;
            end else begin
              o_byte_idx <= o_byte_idx + IDX_W'(1);
            end
          end
        end

        ST_DRAIN: begin
          if (i_tx_en_n) begin
            stop_pend <= 1'b1;
          end
          if (i_tx_idle) begin
            o_seq_count <= o_seq_count + CNT_W'(1);
            o_seq_done  <= 1'b1;
            if (run_limit_hit) begin
              run_cnt  <= run_nxt;
              state    <= ST_HALT;
              o_halted <= 1'b1;
            end else if (stop_now) begin
              run_cnt   <= '0;
              stop_pend <= 1'b0;
              state     <= ST_IDLE;
              o_busy    <= 1'b0;
            end else if (GAP_CYCLES == 0) begin
              run_cnt    <= run_nxt;
              state      <= ST_SEND;
              o_byte_vld <= 1'b1;
              o_byte_idx <= '0;
            end else begin
              run_cnt <= run_nxt;
              gap_cnt <= GAP_LOAD;
              state   <= ST_GAP;
            end
          end
        end

        ST_GAP: begin
          if (i_tx_en_n) begin
            run_cnt <= '0;
            gap_cnt <= '0;
            state   <= ST_IDLE;
            o_busy  <= 1'b0;
          end else if (gap_cnt <= GAP_W'(1)) begin
            gap_cnt    <= '0;
            state      <= ST_SEND;
            o_byte_vld <= 1'b1;
            o_byte_idx <= '0;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end

        ST_HALT: begin
          if (i_tx_en_n) begin
            run_cnt   <= '0;
            stop_pend <= 1'b0;
            state     <= ST_IDLE;
            o_busy    <= 1'b0;
            o_halted  <= 1'b0;
          end
        end

        default: begin
          state      <= ST_IDLE;
          run_cnt    <= '0;
          gap_cnt    <= '0;
          stop_pend  <= 1'b0;
          o_byte_vld <= 1'b0;
          o_busy     <= 1'b0;
          o_halted   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_seq_ctrl.sv
// tb/tb_tx_seq_ctrl.sv - directed self-checking bench for tx_seq_ctrl
module tb_tx_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       en_n = 1'b1;
  logic       rdy  = 1'b1;
  logic       idle = 1'b1;
  logic       vld;
  logic [3:0] idx;
  logic       busy;
  logic       done;
  logic       halted;
  logic [7:0] cnt;

  logic       en2_n = 1'b1;
  logic       rdy2  = 1'b1;
  logic       idle2 = 1'b1;
  logic       vld2;
  logic [3:0] idx2;
  logic       busy2;
  logic       done2;
  logic       halted2;
  logic [1:0] cnt2;

  int n_pass  = 0;
  int n_total = 0;

  // 100 MHz clock
  always #5 clk = ~clk;

  tx_seq_ctrl #(
    .MSG_LEN(14), .IDX_W(4), .GAP_CYCLES(8), .CNT_W(8), .REPEAT(0)
  ) u_dut (
    .i_clk(clk), .i_rst(rst), .i_tx_en_n(en_n), .i_byte_rdy(rdy), .i_tx_idle(idle),
    .o_byte_vld(vld), .o_byte_idx(idx), .o_busy(busy), .o_seq_done(done),
    .o_halted(halted), .o_seq_count(cnt)
  );

  tx_seq_ctrl #(
    .MSG_LEN(14), .IDX_W(4), .GAP_CYCLES(0), .CNT_W(2), .REPEAT(3)
  ) u_rep (
    .i_clk(clk), .i_rst(rst), .i_tx_en_n(en2_n), .i_byte_rdy(rdy2), .i_tx_idle(idle2),
    .o_byte_vld(vld2), .o_byte_idx(idx2), .o_busy(busy2), .o_seq_done(done2),
    .o_halted(halted2), .o_seq_count(cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Three messages back to back, then HALT; base is o_seq_count at entry
  task automatic dut2_run(input int base);
    en2_n = 1'b0;
    @(negedge clk);
    for (int m = 0; m < 3; m++) begin
      for (int i = 0; i < 14; i++) begin
        chk("rep_vld", vld2, 1);
        chk("rep_idx", idx2, i);
        if (i == 0) begin
          chk("rep_done_at_idx0", done2, (m > 0) ? 1 : 0);
          chk("rep_count", cnt2, (base + m) % 4);
        end
        @(negedge clk);
      end
      chk("rep_drain_vld", vld2, 0);
      chk("rep_drain_halted", halted2, 0);
      @(negedge clk);
    end
    chk("rep_halted", halted2, 1);
    chk("rep_halt_done", done2, 1);
    chk("rep_halt_count", cnt2, (base + 3) % 4);
    chk("rep_halt_vld", vld2, 0);
    chk("rep_halt_busy", busy2, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rep_hold_vld", vld2, 0);
      chk("rep_hold_halted", halted2, 1);
      chk("rep_hold_done", done2, 0);
    end
    en2_n = 1'b1;
    @(negedge clk);
    chk("rep_release_halted", halted2, 0);
    chk("rep_release_busy", busy2, 0);
  endtask

  initial begin
    int lows;
    int dones;
    int done_pos;
    int busy_drops;
    int exp_i;
    int hs;
    int k;
    int waitc;

    // Reset state
    @(negedge clk);
    chk("rst_vld", vld, 0);
    chk("rst_idx", idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_halted", halted, 0);
    chk("rst_count", cnt, 0);

    // Message 1: enable held, rdy and idle tied high
    rst  = 1'b0;
    en_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      chk("m1_vld", vld, 1);
      chk("m1_idx", idx, i);
      chk("m1_busy", busy, 1);
      @(negedge clk);
    end

    // DRAIN plus GAP: vld low for 1 + GAP_CYCLES cycles, done in the 2nd
    lows = 0; dones = 0; done_pos = -1; busy_drops = 0;
    while (!vld && lows < 40) begin
      if (done) begin
        dones = dones + 1;
        done_pos = lows;
      end
      if (!busy) busy_drops = busy_drops + 1;
      lows = lows + 1;
      @(negedge clk);
    end
    chk("gap_low_cycles", lows, 9);
    chk("m1_done_pulses", dones, 1);
    chk("m1_done_position", done_pos, 1);
    chk("gap_busy_drops", busy_drops, 0);
    chk("m1_count", cnt, 1);
    chk("m2_first_idx", idx, 0);

    // Message 2: rdy alternates 0,1,0,1 - each index held while rdy=0
    exp_i = 0; hs = 0; k = 0;
    while (hs < 14 && k < 60) begin
      chk("m2_vld", vld, 1);
      chk("m2_idx", idx, exp_i);
      rdy = (k % 2 == 1);
      @(negedge clk);
      if (rdy) begin
        exp_i = exp_i + 1;
        hs = hs + 1;
      end
      k = k + 1;
    end
    rdy = 1'b1;
    chk("m2_cycles", k, 28);
    chk("m2_after_vld", vld, 0);

    waitc = 0;
    while (!vld && waitc < 40) begin
      waitc = waitc + 1;
      @(negedge clk);
    end
    chk("m3_start_vld", vld, 1);
    chk("m2_count", cnt, 2);

    // Message 3: enable released at idx 5, message still completes
    for (int i = 0; i < 14; i++) begin
      chk("m3_vld", vld, 1);
      chk("m3_idx", idx, i);
      if (i == 5) begin
        en_n = 1'b1;
        idle = 1'b0;
      end
      @(negedge clk);
    end
    for (int j = 0; j < 3; j++) begin
      chk("m3_drain_vld", vld, 0);
      chk("m3_drain_busy", busy, 1);
      chk("m3_drain_done", done, 0);
      chk("m3_drain_count", cnt, 2);
      @(negedge clk);
    end
    idle = 1'b1;
    @(negedge clk);
    chk("m3_done", done, 1);
    chk("m3_count", cnt, 3);
    chk("m3_idle_busy", busy, 0);
    @(negedge clk);
    chk("m3_done_once", done, 0);
    @(negedge clk);
    chk("idle_vld", vld, 0);
    chk("idle_busy", busy, 0);

    // Asynchronous reset in the middle of SEND at idx 7
    en_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      chk("m4_idx", idx, i);
      if (i < 7) @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    chk("async_rst_vld", vld, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_count", cnt, 0);
    chk("async_rst_idx", idx, 0);
    @(negedge clk);
    rst  = 1'b0;
    en_n = 1'b1;
    @(negedge clk);
    chk("post_rst_vld", vld, 0);

    // Bounded repeat, CNT_W=2 wrap, GAP_CYCLES=0
    dut2_run(0);
    dut2_run(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

endmodule
